// File: rtl/ctr64_burst_arbiter.sv
// Two-requester round-robin burst sequencer for the 16x4 bit-addressed array.
// Optional burst parity output enabled by defining CTR64_BURST_PARITY_EN.
module ctr64_burst_arbiter #(
    parameter int unsigned GAP     = 1,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic       tick,
    input  logic       clr_n,
    input  logic [1:0] req,
    input  logic [1:0] wr,
    input  logic [5:0] addr0,
    input  logic [5:0] addr1,
    input  logic [5:0] len0,
    input  logic [5:0] len1,
    input  logic [1:0] wd,
    input  logic       bit_rd,
    output logic [1:0] gnt,
    output logic       step,
    output logic [3:0] rg_a,
    output logic [1:0] bit_a,
    output logic       bit_we,
    output logic       bit_wd,
    output logic       rd_bit,
    output logic       rd_vld,
`ifdef CTR64_BURST_PARITY_EN
    output logic       parity,
`endif
    output logic [1:0] done
);

    localparam int unsigned AW = 6;
    localparam int unsigned RW = 7;
    localparam int unsigned GW = 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_GAPW} state_t;

    state_t         r_state, w_state;
    logic [1:0]     r_gnt, w_gnt;
    logic           r_step, w_step;
    logic [AW-1:0]  r_addr, w_addr;
    logic           r_we, w_we;
    logic           r_wd, w_wd;
    logic           r_rd_bit, w_rd_bit;
    logic           r_rd_vld, w_rd_vld;
    logic [1:0]     r_done, w_done;
    logic [RW-1:0]  r_rem, w_rem;
    logic           r_own, w_own;
    logic           r_wr, w_wr;
    logic           r_rr, w_rr;
    logic [GW-1:0]  r_gap, w_gap;
    logic           r_par, w_par;
    logic           w_arb;
    logic           w_win;
    logic [AW-1:0]  w_len;
    logic [RW-1:0]  w_len_bits;

    // State and output registers
    always_ff @(posedge tick or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= 2'b00;
            r_step   <= 1'b0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wd     <= 1'b0;
            r_rd_bit <= 1'b0;
            r_rd_vld <= 1'b0;
            r_done   <= 2'b00;
            r_rem    <= '0;
            r_own    <= 1'b0;
            r_wr     <= 1'b0;
            r_rr     <= RR_INIT;
            r_gap    <= '0;
            r_par    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_gnt    <= w_gnt;
            r_step   <= w_step;
            r_addr   <= w_addr;
            r_we     <= w_we;
            r_wd     <= w_wd;
            r_rd_bit <= w_rd_bit;
            r_rd_vld <= w_rd_vld;
            r_done   <= w_done;
            r_rem    <= w_rem;
            r_own    <= w_own;
            r_wr     <= w_wr;
            r_rr     <= w_rr;
            r_gap    <= w_gap;
            r_par    <= w_par;
        end
    end

    // Next-state, arbitration and bit sequencing
    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_step   = 1'b0;
        w_addr   = r_addr;
        w_we     = 1'b0;
        w_wd     = 1'b0;
        w_rd_bit = r_rd_bit;
        w_rd_vld = 1'b0;
        w_done   = 2'b00;
        w_rem    = r_rem;
        w_own    = r_own;
        w_wr     = r_wr;
        w_rr     = r_rr;
        w_gap    = r_gap;
        w_par    = r_par;
        w_arb    = 1'b0;

        w_win      = (req == 2'b10) ? 1'b1 : ((req == 2'b01) ? 1'b0 : r_rr);
        w_len      = w_win ? len1 : len0;
        w_len_bits = (w_len == 6'd0) ? RW'(64) : RW'(w_len);

        // Capture the bit moved during the previous step
        if (r_step) begin
            w_par = r_par ^ (r_wr ? r_wd : bit_rd);
            if (!r_wr) begin
                w_rd_bit = bit_rd;
                w_rd_vld = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: w_arb = 1'b1;
            S_RUN: begin
                if (r_rem == RW'(0)) begin
                    w_state = S_DONE;
                    w_gnt   = 2'b00;
                    w_done  = r_own ? 2'b10 : 2'b01;
                    w_rr    = ~r_own;
                end else begin
                    w_step = 1'b1;
                    w_addr = r_addr + AW'(1);
                    w_we   = r_wr;
                    w_wd   = r_wr & wd[r_own];
                    w_rem  = r_rem - RW'(1);
                end
            end
            S_DONE: begin
                if (GAP == 0) begin
                    w_state = S_IDLE;
                    w_arb   = 1'b1;
                end else begin
                    w_state = S_GAPW;
                    w_gap   = GW'(GAP);
                end
            end
            S_GAPW: begin
                w_gap = r_gap - GW'(1);
                if (r_gap <= GW'(1)) begin
                    w_state = S_IDLE;
                    w_arb   = 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // The last idle tick arbitrates so a grant lands right after the gap
        if (w_arb && (req != 2'b00)) begin
            w_state = S_RUN;
            w_gnt   = w_win ? 2'b10 : 2'b01;
            w_step  = 1'b1;
            w_addr  = w_win ? addr1 : addr0;
            w_we    = wr[w_win];
            w_wd    = wr[w_win] & wd[w_win];
            w_rem   = w_len_bits - RW'(1);
            w_own   = w_win;
            w_wr    = wr[w_win];
            w_par   = 1'b0;
        end
    end

    assign gnt    = r_gnt;
    assign step   = r_step;
    assign rg_a   = r_addr[5:2];
    assign bit_a  = r_addr[1:0];
    assign bit_we = r_we;
    assign bit_wd = r_wd;
    assign rd_bit = r_rd_bit;
    assign rd_vld = r_rd_vld;
    assign done   = r_done;
`ifdef CTR64_BURST_PARITY_EN
    assign parity = r_par;
`endif

endmodule

// File: tb/tb_ctr64_burst_arbiter.sv
// Directed bench for ctr64_burst_arbiter with a behavioural 64-bit array model.
// Define CTR64_BURST_PARITY_EN to also exercise the parity output.
module tb_ctr64_burst_arbiter;

    logic       tick = 1'b0;
    logic       clr_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] wr = 2'b00;
    logic [5:0] addr0 = '0;
    logic [5:0] addr1 = '0;
    logic [5:0] len0 = '0;
    logic [5:0] len1 = '0;
    logic [1:0] wd = 2'b00;
    logic       bit_rd;
    logic [1:0] gnt;
    logic       step;
    logic [3:0] rg_a;
    logic [1:0] bit_a;
    logic       bit_we;
    logic       bit_wd;
    logic       rd_bit;
    logic       rd_vld;
    logic [1:0] done;
`ifdef CTR64_BURST_PARITY_EN
    logic       parity;
`endif

    logic [63:0] mem = 64'hA5C3_0F96_1234_8E7B;
    int n_checks = 0;
    int n_fail   = 0;

    ctr64_burst_arbiter #(.GAP(1), .RR_INIT(1'b0)) u_dut (
        .tick   (tick),
        .clr_n  (clr_n),
        .req    (req),
        .wr     (wr),
        .addr0  (addr0),
        .addr1  (addr1),
        .len0   (len0),
        .len1   (len1),
        .wd     (wd),
        .bit_rd (bit_rd),
        .gnt    (gnt),
        .step   (step),
        .rg_a   (rg_a),
        .bit_a  (bit_a),
        .bit_we (bit_we),
        .bit_wd (bit_wd),
        .rd_bit (rd_bit),
        .rd_vld (rd_vld),
`ifdef CTR64_BURST_PARITY_EN
        .parity (parity),
`endif
        .done   (done)
    );

    always #5 tick = ~tick;

    // Array model: combinational read, write on the rising edge
    assign bit_rd = mem[{rg_a, bit_a}];
    always @(posedge tick) begin
        if (bit_we) mem[{rg_a, bit_a}] <= bit_wd;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one request, wait for grant, check every bit and the done tick
    task automatic burst(input logic [1:0] rq, input int own, input logic w,
                         input logic [5:0] a, input int len, input logic [63:0] pat,
                         input int exp_wait);
        logic [1:0] oh;
        logic [5:0] ad;
        logic       par;
        int         waited;
        oh     = (own != 0) ? 2'b10 : 2'b01;
        par    = 1'b0;
        waited = 0;
        req    = rq;
        wd     = {2{pat[0]}};
        do begin
            @(posedge tick); #1;
            waited++;
        end while (gnt == 2'b00 && waited < 20);
        check("grant_wait", 64'(waited), 64'(exp_wait));
        if (gnt == 2'b00) return;
        req = rq & ~gnt;
        for (int k = 0; k < len; k++) begin
            ad = a + 6'(k);
            check("gnt", 64'(gnt), 64'(oh));
            check("step", 64'(step), 64'd1);
            check("addr", 64'({rg_a, bit_a}), 64'(ad));
            check("bit_we", 64'(bit_we), 64'(w));
            if (w) begin
                check("bit_wd", 64'(bit_wd), 64'(pat[k]));
                par ^= pat[k];
            end else begin
                par ^= mem[ad];
                if (k == 0) begin
                    check("rd_vld_first", 64'(rd_vld), 64'd0);
                end else begin
                    check("rd_vld", 64'(rd_vld), 64'd1);
                    check("rd_bit", 64'(rd_bit), 64'(mem[ad - 6'd1]));
                end
            end
            if (k < 63) wd = {2{pat[k + 1]}};
            @(posedge tick); #1;
        end
        ad = a + 6'(len - 1);
        check("done", 64'(done), 64'(oh));
        check("gnt_done", 64'(gnt), 64'd0);
        check("step_done", 64'(step), 64'd0);
        check("we_done", 64'(bit_we), 64'd0);
        check("addr_hold", 64'({rg_a, bit_a}), 64'(ad));
        if (!w) begin
            check("rd_vld_last", 64'(rd_vld), 64'd1);
            check("rd_bit_last", 64'(rd_bit), 64'(mem[ad]));
        end
`ifdef CTR64_BURST_PARITY_EN
        check("parity", 64'(parity), 64'(par));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge tick);
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_step", 64'(step), 64'd0);
        check("rst_addr", 64'({rg_a, bit_a}), 64'd0);
        check("rst_rd_vld", 64'(rd_vld), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        clr_n = 1'b1;

        // Write burst from requester 0, three bits from 0x05
        wr = 2'b01; addr0 = 6'h05; len0 = 6'd3;
        burst(2'b01, 0, 1'b1, 6'h05, 3, 64'b101, 1);
        check("mem_w0", 64'(mem[7:5]), 64'b101);

        // Read burst from requester 1 wrapping 0x3F -> 0x00
        wr = 2'b00; addr1 = 6'h3E; len1 = 6'd4;
        burst(2'b10, 1, 1'b0, 6'h3E, 4, 64'd0, 2);

        // Both requesting: rr pointer now on 0, then alternate
        wr = 2'b11; addr0 = 6'h10; addr1 = 6'h20; len0 = 6'd2; len1 = 6'd2;
        burst(2'b11, 0, 1'b1, 6'h10, 2, 64'b10, 2);
        burst(2'b10, 1, 1'b1, 6'h20, 2, 64'b01, 2);
        burst(2'b11, 0, 1'b1, 6'h10, 2, 64'b11, 2);
        check("mem_rr", 64'({mem[33:32], mem[17:16]}), 64'b0111);

        // Full 64-bit burst with len=0
        wr = 2'b01; addr0 = 6'h00; len0 = 6'd0;
        burst(2'b01, 0, 1'b1, 6'h00, 64, 64'hDEAD_BEEF_0123_4567, 2);
        check("mem_full", mem, 64'hDEAD_BEEF_0123_4567);

        // Reset in the middle of a burst
        wr = 2'b01; addr0 = 6'h08; len0 = 6'd5; req = 2'b01;
        for (int i = 0; i < 20 && gnt == 2'b00; i++) begin
            @(posedge tick); #1;
        end
        check("mid_gnt", 64'(gnt), 64'b01);
        @(posedge tick); #1;
        check("mid_addr", 64'({rg_a, bit_a}), 64'h09);
        clr_n = 1'b0;
        #1;
        check("abort_gnt", 64'(gnt), 64'd0);
        check("abort_step", 64'(step), 64'd0);
        check("abort_we", 64'(bit_we), 64'd0);
        check("abort_addr", 64'({rg_a, bit_a}), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        req = 2'b00;
        @(posedge tick); #1;
        clr_n = 1'b1;
        wr = 2'b00; addr0 = 6'h30; addr1 = 6'h31; len0 = 6'd2; len1 = 6'd2;
        burst(2'b11, 0, 1'b0, 6'h30, 2, 64'd0, 1);
        req = 2'b00;
        @(posedge tick); #1;
        check("done_pulse", 64'(done), 64'd0);

`ifdef CTR64_BURST_PARITY_EN
        wr = 2'b01; addr0 = 6'h2C; len0 = 6'd4;
        burst(2'b01, 0, 1'b1, 6'h2C, 4, 64'b1011, 1);
        check("parity_1101", 64'(parity), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
